// File: rtl/trap_ctrl_if.sv
// Trap sequencer bus bundle.
// Carries the EXU event handshake, CSR read/write ports, the IFU redirect
// handshake, the flush line and the completed-trap counter.
//   slave  : the trap_ctrl side
//   master : the EXU / CSR / IFU side (or a testbench standing in for them)
interface trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            exc_valid;
  logic            exc_ready;
  logic [1:0]      exc_type;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] csr_mtvec;
  logic [XLEN-1:0] csr_mepc;
  logic            mepc_wen;
  logic [XLEN-1:0] mepc_wdata;
  logic            mcause_wen;
  logic [XLEN-1:0] mcause_wdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;
  logic            flush;
  logic [31:0]     trap_cnt;

  modport slave (
    input  exc_valid, exc_type, exc_pc, csr_mtvec, csr_mepc, redirect_ready,
    output exc_ready, mepc_wen, mepc_wdata, mcause_wen, mcause_wdata,
           redirect_valid, redirect_pc, flush, trap_cnt
  );

  modport master (
    output exc_valid, exc_type, exc_pc, csr_mtvec, csr_mepc, redirect_ready,
    input  exc_ready, mepc_wen, mepc_wdata, mcause_wen, mcause_wdata,
           redirect_valid, redirect_pc, flush, trap_cnt
  );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap/return sequencer between EXU and the CSR file.
// Accepts one ECALL/EBREAK/ILLEGAL/MRET event, writes mepc/mcause for traps,
// then issues a single PC redirect to IFU (mtvec base for traps, mepc for
// MRET). Younger instructions are flushed for the whole sequence.
// Ports:
//   clk_i  clock (posedge)
//   rst_i  asynchronous reset, active-high
//   bus    trap_ctrl_if.slave: event handshake, CSR ports, redirect
//          handshake, flush, completed-trap counter (saturating)
module trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  trap_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SAVE     = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, cause_q, target_q;
  logic            is_trap_q;
  logic [31:0]     cnt_q;

  logic accept, is_mret, handshake;

  assign accept    = bus.exc_valid && (state_q == IDLE);
  assign is_mret   = (bus.exc_type == 2'b11);
  assign handshake = (state_q == REDIRECT) && bus.redirect_ready;

  function automatic logic [XLEN-1:0] cause_of(input logic [1:0] t);
    logic [XLEN-1:0] c;
    c = '0;
    case (t)
      2'b00:   c = XLEN'(5'd11); // ECALL from M-mode
      2'b01:   c = XLEN'(5'd3);  // breakpoint
      2'b10:   c = XLEN'(5'd2);  // illegal instruction
      default: c = '0;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Event fields are captured only on the accept edge; later EXU changes
  // are ignored. Targets drop the low two bits (mtvec mode is ignored since
  // exceptions always vector to base).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q      <= '0;
      cause_q   <= '0;
      target_q  <= '0;
      is_trap_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        pc_q      <= {bus.exc_pc[XLEN-1:2], 2'b00};
        cause_q   <= cause_of(bus.exc_type);
        is_trap_q <= !is_mret;
        if (is_mret) target_q <= {bus.csr_mepc[XLEN-1:2], 2'b00};
      end
      if (state_q == SAVE) target_q <= {bus.csr_mtvec[XLEN-1:2], 2'b00};
      if (handshake && is_trap_q && (cnt_q != 32'hFFFF_FFFF))
        cnt_q <= cnt_q + 32'd1;
    end
  end

  always_comb begin
    state_d            = state_q;
    bus.exc_ready      = 1'b0;
    bus.mepc_wen       = 1'b0;
    bus.mepc_wdata     = '0;
    bus.mcause_wen     = 1'b0;
    bus.mcause_wdata   = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    case (state_q)
      IDLE: begin
        bus.exc_ready = 1'b1;
        if (bus.exc_valid) state_d = is_mret ? REDIRECT : SAVE;
      end
      SAVE: begin
        bus.mepc_wen     = 1'b1;
        bus.mepc_wdata   = pc_q;
        bus.mcause_wen   = 1'b1;
        bus.mcause_wdata = cause_q;
        state_d          = REDIRECT;
      end
      REDIRECT: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target_q;
        if (bus.redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Flush covers the accept cycle itself through the redirect handshake.
  assign bus.flush    = (state_q != IDLE) || accept;
  assign bus.trap_cnt = cnt_q;

endmodule
